// File: rtl/main_memory_bus_arbiter_pkg.sv
// Shared encodings and helpers for the main-memory bus arbiter slice.
// Message encodings mirror the cache hierarchy's shared parameter set.
package main_memory_bus_arbiter_pkg;

  localparam int DEF_STATUS_BITS    = 2;
  localparam int DEF_COHERENCE_BITS = 2;
  localparam int DEF_OFFSET_BITS    = 2;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_ADDRESS_WIDTH  = 12;
  localparam int DEF_MSG_BITS       = 3;
  localparam int DEF_NUM_CACHES     = 4;

  typedef logic [2:0] msg_t;

  // Request-side and response-side codes share the same 3-bit space.
  localparam msg_t NO_REQ    = 3'd0;
  localparam msg_t R_REQ     = 3'd1;
  localparam msg_t WB_REQ    = 3'd2;
  localparam msg_t FLUSH     = 3'd3;
  localparam msg_t INVLD     = 3'd4;
  localparam msg_t WS_BCAST  = 3'd5;
  localparam msg_t RFO_BCAST = 3'd6;
  localparam msg_t NO_FLUSH  = 3'd7;
  localparam msg_t MEM_READY = 3'd1;
  localparam msg_t M_RECV    = 3'd2;
  localparam msg_t REQ_FLUSH = 3'd3;

  function automatic int log2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic logic isRequest(input msg_t msg);
    return (msg == R_REQ) || (msg == WB_REQ) || (msg == FLUSH) || (msg == INVLD);
  endfunction

  // Reads/writebacks finish on MEM_READY; flushes/invalidates finish on M_RECV.
  function automatic logic isComplete(input msg_t req, input msg_t resp);
    return (((req == R_REQ) || (req == WB_REQ)) && (resp == MEM_READY)) ||
           (((req == FLUSH) || (req == INVLD)) && (resp == M_RECV));
  endfunction

endpackage

// File: rtl/main_memory_bus_arbiter_if.sv
// Bundle of per-lane cache signals, the memory port and the grant status.
// The slave modport is the arbiter's view; master is the environment's view.
interface main_memory_bus_arbiter_if
  import main_memory_bus_arbiter_pkg::*;
#(
  parameter int STATUS_BITS    = DEF_STATUS_BITS,
  parameter int COHERENCE_BITS = DEF_COHERENCE_BITS,
  parameter int OFFSET_BITS    = DEF_OFFSET_BITS,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int MSG_BITS       = DEF_MSG_BITS,
  parameter int NUM_CACHES     = DEF_NUM_CACHES
);
  localparam int BUS_WIDTH = STATUS_BITS + COHERENCE_BITS + DATA_WIDTH * (1 << OFFSET_BITS);
  localparam int GW        = log2(NUM_CACHES);

  logic [NUM_CACHES*MSG_BITS-1:0]      cache_msg_in;
  logic [NUM_CACHES*ADDRESS_WIDTH-1:0] cache_address_in;
  logic [NUM_CACHES*BUS_WIDTH-1:0]     cache_data_in;
  logic [NUM_CACHES*MSG_BITS-1:0]      cache_msg_out;
  logic [NUM_CACHES*BUS_WIDTH-1:0]     cache_data_out;
  logic [NUM_CACHES*ADDRESS_WIDTH-1:0] cache_address_out;
  logic [MSG_BITS-1:0]                 mem_msg_out;
  logic [ADDRESS_WIDTH-1:0]            mem_address_out;
  logic [BUS_WIDTH-1:0]                mem_data_out;
  logic [MSG_BITS-1:0]                 mem_msg_in;
  logic [ADDRESS_WIDTH-1:0]            mem_address_in;
  logic [BUS_WIDTH-1:0]                mem_data_in;
  logic                                grant_valid;
  logic [GW-1:0]                       grant_id;

  modport master (
    output cache_msg_in, cache_address_in, cache_data_in,
    output mem_msg_in, mem_address_in, mem_data_in,
    input  cache_msg_out, cache_data_out, cache_address_out,
    input  mem_msg_out, mem_address_out, mem_data_out,
    input  grant_valid, grant_id
  );

  modport slave (
    input  cache_msg_in, cache_address_in, cache_data_in,
    input  mem_msg_in, mem_address_in, mem_data_in,
    output cache_msg_out, cache_data_out, cache_address_out,
    output mem_msg_out, mem_address_out, mem_data_out,
    output grant_valid, grant_id
  );

endinterface

// File: rtl/main_memory_bus_arbiter_rr_priority_select.sv
// Round-robin pick: first requesting lane at or after the pointer, wrapping.
// Purely combinational; the pointer itself is held by the caller.
module rr_priority_select
  import main_memory_bus_arbiter_pkg::*;
#(
  parameter  int NUM_CACHES = DEF_NUM_CACHES,
  localparam int GW         = log2(NUM_CACHES)
) (
  input  logic [NUM_CACHES-1:0] i_req,
  input  logic [GW-1:0]         i_ptr,
  output logic [GW-1:0]         o_grant,
  output logic                  o_valid
);

  logic [GW:0] w_idx;

  // Scan farthest-first so the lane closest to the pointer is the last write.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int k = NUM_CACHES - 1; k >= 0; k--) begin
      w_idx = {1'b0, i_ptr} + (GW+1)'(k);
      if (w_idx >= (GW+1)'(NUM_CACHES)) w_idx = w_idx - (GW+1)'(NUM_CACHES);
      if (i_req[w_idx[GW-1:0]]) begin
        o_grant = w_idx[GW-1:0];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/main_memory_bus_arbiter.sv
// Serialises per-cache memory lanes onto one main-memory port, round-robin,
// and routes memory responses back to the owning lane only.
module main_memory_bus_arbiter
  import main_memory_bus_arbiter_pkg::*;
#(
  parameter int STATUS_BITS    = DEF_STATUS_BITS,
  parameter int COHERENCE_BITS = DEF_COHERENCE_BITS,
  parameter int OFFSET_BITS    = DEF_OFFSET_BITS,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int MSG_BITS       = DEF_MSG_BITS,
  parameter int NUM_CACHES     = DEF_NUM_CACHES
) (
  input  logic                          clock,
  input  logic                          reset,
  main_memory_bus_arbiter_if.slave      bus
);

  localparam int BUS_WIDTH = STATUS_BITS + COHERENCE_BITS + DATA_WIDTH * (1 << OFFSET_BITS);
  localparam int GW        = log2(NUM_CACHES);

  typedef enum logic [1:0] {ST_IDLE, ST_SERVE, ST_RELEASE} state_t;

  state_t                   r_state;
  state_t                   w_nextState;
  logic [GW-1:0]            r_grantId;
  logic [GW-1:0]            w_nextGrantId;
  logic                     r_grantValid;
  logic                     w_nextGrantValid;
  logic [GW-1:0]            r_rrPtr;
  logic [GW-1:0]            w_nextRrPtr;
  logic [GW-1:0]            w_ptrAfterOwner;
  logic [GW-1:0]            w_selId;
  logic                     w_selValid;
  logic [NUM_CACHES-1:0]    w_reqVec;
  logic [MSG_BITS-1:0]      w_ownMsg;
  logic [ADDRESS_WIDTH-1:0] w_ownAddress;
  logic [BUS_WIDTH-1:0]     w_ownData;

  always_comb begin
    w_reqVec = '0;
    for (int i = 0; i < NUM_CACHES; i++) begin
      w_reqVec[i] = isRequest(bus.cache_msg_in[i*MSG_BITS +: MSG_BITS]);
    end
  end

  assign w_ownMsg        = bus.cache_msg_in[r_grantId*MSG_BITS +: MSG_BITS];
  assign w_ownAddress    = bus.cache_address_in[r_grantId*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign w_ownData       = bus.cache_data_in[r_grantId*BUS_WIDTH +: BUS_WIDTH];
  assign w_ptrAfterOwner = (r_grantId == GW'(NUM_CACHES - 1)) ? '0 : r_grantId + 1'b1;

  rr_priority_select #(.NUM_CACHES(NUM_CACHES)) u_rrSelect (
    .i_req   (w_reqVec),
    .i_ptr   (r_rrPtr),
    .o_grant (w_selId),
    .o_valid (w_selValid)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_grantId    <= '0;
      r_grantValid <= 1'b0;
      r_rrPtr      <= '0;
    end else begin
      r_state      <= w_nextState;
      r_grantId    <= w_nextGrantId;
      r_grantValid <= w_nextGrantValid;
      r_rrPtr      <= w_nextRrPtr;
    end
  end

  // A drop of the owner's request outranks a completion seen in the same cycle.
  always_comb begin
    w_nextState      = r_state;
    w_nextGrantId    = r_grantId;
    w_nextGrantValid = r_grantValid;
    w_nextRrPtr      = r_rrPtr;
    case (r_state)
      ST_IDLE: begin
        if (w_selValid) begin
          w_nextState      = ST_SERVE;
          w_nextGrantId    = w_selId;
          w_nextGrantValid = 1'b1;
        end
      end
      ST_SERVE: begin
        if (!isRequest(w_ownMsg)) begin
          w_nextState      = ST_IDLE;
          w_nextGrantValid = 1'b0;
          w_nextRrPtr      = w_ptrAfterOwner;
        end else if (isComplete(w_ownMsg, bus.mem_msg_in)) begin
          w_nextState = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (w_ownMsg == NO_REQ) begin
          w_nextState      = ST_IDLE;
          w_nextGrantValid = 1'b0;
          w_nextRrPtr      = w_ptrAfterOwner;
        end
      end
      default: begin
        w_nextState      = ST_IDLE;
        w_nextGrantValid = 1'b0;
      end
    endcase
  end

  // Outputs are gated by reset so memory sees NO_REQ while reset is held.
  always_comb begin
    bus.mem_msg_out       = NO_REQ;
    bus.mem_address_out   = '0;
    bus.mem_data_out      = '0;
    bus.cache_msg_out     = {NUM_CACHES{NO_REQ}};
    bus.cache_address_out = '0;
    bus.cache_data_out    = '0;
    if (reset && (r_state == ST_SERVE) && isRequest(w_ownMsg)) begin
      bus.mem_msg_out     = w_ownMsg;
      bus.mem_address_out = w_ownAddress;
      bus.mem_data_out    = w_ownData;
    end
    if (reset && (r_state != ST_IDLE)) begin
      bus.cache_msg_out[r_grantId*MSG_BITS +: MSG_BITS]               = bus.mem_msg_in;
      bus.cache_address_out[r_grantId*ADDRESS_WIDTH +: ADDRESS_WIDTH] = bus.mem_address_in;
      bus.cache_data_out[r_grantId*BUS_WIDTH +: BUS_WIDTH]            = bus.mem_data_in;
    end
  end

  assign bus.grant_valid = r_grantValid;
  assign bus.grant_id    = r_grantId;

endmodule

// File: tb/tb_main_memory_bus_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of ownership, release and round-robin order.
module tb_main_memory_bus_arbiter;
  import main_memory_bus_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int MSGW = 3;
  localparam int AW   = 12;
  localparam int BW   = 2 + 2 + 8 * 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  main_memory_bus_arbiter_if #(.NUM_CACHES(N)) bus ();

  main_memory_bus_arbiter #(.NUM_CACHES(N)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checkCount = 0;
  int passCount  = 0;

  // Model: who owns memory, whether it already completed, and the next-turn lane.
  int mOwner     = 0;
  bit mValid     = 1'b0;
  bit mReleasing = 1'b0;
  int mPtr       = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  function automatic msg_t laneMsgIn(input int l);
    return bus.cache_msg_in[l*MSGW +: MSGW];
  endfunction

  function automatic bit modelIsReq(input msg_t m);
    return m inside {R_REQ, WB_REQ, FLUSH, INVLD};
  endfunction

  function automatic bit modelDone(input msg_t req, input msg_t resp);
    if (req == R_REQ || req == WB_REQ) return resp == MEM_READY;
    return resp == M_RECV;
  endfunction

  task automatic applyStimulus(input int l, input msg_t msg, input logic [AW-1:0] addr, input logic [BW-1:0] data);
    bus.cache_msg_in[l*MSGW +: MSGW]   = msg;
    bus.cache_address_in[l*AW +: AW]   = addr;
    bus.cache_data_in[l*BW +: BW]      = data;
  endtask

  task automatic setMem(input msg_t msg, input logic [AW-1:0] addr, input logic [BW-1:0] data);
    bus.mem_msg_in     = msg;
    bus.mem_address_in = addr;
    bus.mem_data_in    = data;
  endtask

  task automatic checkModel();
    bit fwd;
    bit route;
    checkOutput("grantValid", 64'(bus.grant_valid), 64'(mValid));
    if (mValid) checkOutput("grantId", 64'(bus.grant_id), 64'(mOwner));
    fwd = reset && mValid && !mReleasing && modelIsReq(laneMsgIn(mOwner));
    checkOutput("memMsgOut",  64'(bus.mem_msg_out),     fwd ? 64'(laneMsgIn(mOwner)) : 64'(NO_REQ));
    checkOutput("memAddrOut", 64'(bus.mem_address_out), fwd ? 64'(bus.cache_address_in[mOwner*AW +: AW]) : 64'(0));
    checkOutput("memDataOut", 64'(bus.mem_data_out),    fwd ? 64'(bus.cache_data_in[mOwner*BW +: BW]) : 64'(0));
    for (int l = 0; l < N; l++) begin
      route = reset && mValid && (l == mOwner);
      checkOutput($sformatf("laneMsgOut%0d", l), 64'(bus.cache_msg_out[l*MSGW +: MSGW]),
                  route ? 64'(bus.mem_msg_in) : 64'(NO_REQ));
      checkOutput($sformatf("laneAddrOut%0d", l), 64'(bus.cache_address_out[l*AW +: AW]),
                  route ? 64'(bus.mem_address_in) : 64'(0));
      checkOutput($sformatf("laneDataOut%0d", l), 64'(bus.cache_data_out[l*BW +: BW]),
                  route ? 64'(bus.mem_data_in) : 64'(0));
    end
  endtask

  task automatic advanceModel();
    msg_t own;
    own = laneMsgIn(mOwner);
    if (!reset) begin
      mValid = 1'b0; mReleasing = 1'b0; mPtr = 0; mOwner = 0;
    end else if (!mValid) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (modelIsReq(laneMsgIn((mPtr + k) % N))) begin
          mOwner = (mPtr + k) % N; mValid = 1'b1; mReleasing = 1'b0;
        end
      end
    end else if (!mReleasing) begin
      if (!modelIsReq(own)) begin
        mValid = 1'b0; mPtr = (mOwner + 1) % N;
      end else if (modelDone(own, msg_t'(bus.mem_msg_in))) begin
        mReleasing = 1'b1;
      end
    end else if (own == NO_REQ) begin
      mValid = 1'b0; mReleasing = 1'b0; mPtr = (mOwner + 1) % N;
    end
  endtask

  task automatic runCycle();
    #1;
    checkModel();
    advanceModel();
    @(negedge clock);
  endtask

  task automatic resetDut();
    for (int l = 0; l < N; l++) applyStimulus(l, NO_REQ, '0, '0);
    setMem(NO_REQ, '0, '0);
    reset = 1'b0;
    runCycle();
    reset = 1'b1;
  endtask

  task automatic waitGrant(input string tag);
    int i;
    i = 0;
    #1;
    while (!bus.grant_valid && i < 8) begin
      runCycle();
      #1;
      i++;
    end
    checkOutput(tag, 64'(bus.grant_valid), 64'(1));
  endtask

  initial begin
    msg_t choices[7];
    msg_t memChoices[4];
    msg_t cur;
    choices    = '{R_REQ, WB_REQ, FLUSH, INVLD, WS_BCAST, RFO_BCAST, NO_REQ};
    memChoices = '{NO_REQ, MEM_READY, M_RECV, REQ_FLUSH};
    for (int l = 0; l < N; l++) applyStimulus(l, NO_REQ, '0, '0);
    setMem(NO_REQ, '0, '0);
    reset = 1'b0;
    @(negedge clock);

    // Reset held with lane0 requesting, then grant right after release.
    applyStimulus(0, R_REQ, 12'h100, 36'h1);
    repeat (2) begin
      #1;
      checkOutput("rstGrantValid", 64'(bus.grant_valid), 64'(0));
      checkOutput("rstGrantId", 64'(bus.grant_id), 64'(0));
      checkOutput("rstMemMsg", 64'(bus.mem_msg_out), 64'(NO_REQ));
      checkOutput("rstLane0Msg", 64'(bus.cache_msg_out[0 +: MSGW]), 64'(NO_REQ));
      runCycle();
    end
    reset = 1'b1;
    #1;
    checkOutput("relNoGrantYet", 64'(bus.grant_valid), 64'(0));
    runCycle();
    #1;
    checkOutput("relGrantValid", 64'(bus.grant_valid), 64'(1));
    checkOutput("relGrantId", 64'(bus.grant_id), 64'(0));
    checkOutput("relMemMsg", 64'(bus.mem_msg_out), 64'(R_REQ));
    setMem(MEM_READY, 12'h100, 36'hA5);
    runCycle();
    applyStimulus(0, NO_REQ, '0, '0);
    setMem(NO_REQ, '0, '0);
    runCycle();

    // Three simultaneous readers served in order 1,2,3.
    resetDut();
    for (int k = 1; k < N; k++) applyStimulus(k, R_REQ, AW'(12'h200 + k), BW'(k));
    for (int k = 1; k < N; k++) begin
      waitGrant("s2Grant");
      checkOutput("s2GrantId", 64'(bus.grant_id), 64'(k));
      setMem(MEM_READY, 12'h200, BW'(36'hA5 + k));
      #1;
      checkOutput("s2LaneMsg", 64'(bus.cache_msg_out[k*MSGW +: MSGW]), 64'(MEM_READY));
      checkOutput("s2LaneData", 64'(bus.cache_data_out[k*BW +: BW]), 64'(36'hA5 + k));
      runCycle();
      applyStimulus(k, NO_REQ, '0, '0);
      setMem(NO_REQ, '0, '0);
      runCycle();
    end

    // Writeback address is visible on the grant cycle; release holds until NO_REQ.
    resetDut();
    applyStimulus(2, WB_REQ, 12'h3F0, 36'h123456789);
    waitGrant("s3Grant");
    checkOutput("s3GrantId", 64'(bus.grant_id), 64'(2));
    checkOutput("s3MemAddr", 64'(bus.mem_address_out), 64'(12'h3F0));
    checkOutput("s3MemMsg", 64'(bus.mem_msg_out), 64'(WB_REQ));
    setMem(MEM_READY, 12'h3F0, '0);
    runCycle();
    setMem(NO_REQ, '0, '0);
    repeat (2) begin
      #1;
      checkOutput("s3RelMemMsg", 64'(bus.mem_msg_out), 64'(NO_REQ));
      checkOutput("s3RelHeld", 64'(bus.grant_valid), 64'(1));
      runCycle();
    end
    applyStimulus(2, NO_REQ, '0, '0);
    runCycle();
    #1;
    checkOutput("s3Idle", 64'(bus.grant_valid), 64'(0));

    // Flush ignores MEM_READY and completes only on M_RECV.
    resetDut();
    applyStimulus(0, FLUSH, 12'h040, 36'hF0F0);
    waitGrant("s4Grant");
    setMem(MEM_READY, '0, '0);
    repeat (2) begin
      #1;
      checkOutput("s4StayGrant", 64'(bus.grant_valid), 64'(1));
      checkOutput("s4StayMsg", 64'(bus.mem_msg_out), 64'(FLUSH));
      runCycle();
    end
    setMem(M_RECV, '0, '0);
    runCycle();
    #1;
    checkOutput("s4RelMsg", 64'(bus.mem_msg_out), 64'(NO_REQ));
    checkOutput("s4RelGrant", 64'(bus.grant_valid), 64'(1));
    applyStimulus(0, NO_REQ, '0, '0);
    setMem(NO_REQ, '0, '0);
    runCycle();

    // Abort racing completion: abort wins and the pointer moves past lane1.
    resetDut();
    applyStimulus(1, R_REQ, 12'h111, 36'h11);
    waitGrant("s5Grant");
    checkOutput("s5GrantId", 64'(bus.grant_id), 64'(1));
    applyStimulus(1, NO_REQ, '0, '0);
    setMem(MEM_READY, '0, '0);
    #1;
    checkOutput("s5AbortMsg", 64'(bus.mem_msg_out), 64'(NO_REQ));
    runCycle();
    #1;
    checkOutput("s5AbortIdle", 64'(bus.grant_valid), 64'(0));
    setMem(NO_REQ, '0, '0);
    applyStimulus(0, R_REQ, 12'h001, 36'h1);
    applyStimulus(1, R_REQ, 12'h002, 36'h2);
    applyStimulus(3, R_REQ, 12'h003, 36'h3);
    runCycle();
    #1;
    checkOutput("s5PtrAfterAbort", 64'(bus.grant_id), 64'(3));
    for (int l = 0; l < N; l++) applyStimulus(l, NO_REQ, '0, '0);
    runCycle();

    // Broadcast-only traffic never claims memory.
    resetDut();
    applyStimulus(3, WS_BCAST, 12'h3C0, 36'h5);
    repeat (20) begin
      #1;
      checkOutput("s6MemMsg", 64'(bus.mem_msg_out), 64'(NO_REQ));
      checkOutput("s6NoGrant", 64'(bus.grant_valid), 64'(0));
      runCycle();
    end

    // Random traffic against the model.
    resetDut();
    for (int c = 0; c < 3000; c++) begin
      for (int l = 0; l < N; l++) begin
        cur = laneMsgIn(l);
        if (cur == NO_REQ) begin
          if ($urandom_range(0, 3) == 0)
            applyStimulus(l, choices[$urandom_range(0, 6)], AW'($urandom()), BW'({$urandom(), $urandom()}));
        end else if (!modelIsReq(cur)) begin
          if ($urandom_range(0, 2) == 0) applyStimulus(l, NO_REQ, '0, '0);
        end else if ((mValid && mReleasing && mOwner == l && $urandom_range(0, 1) == 0) ||
                     $urandom_range(0, 15) == 0) begin
          applyStimulus(l, NO_REQ, '0, '0);
        end else if ($urandom_range(0, 31) == 0) begin
          applyStimulus(l, choices[$urandom_range(0, 3)], AW'($urandom()), BW'({$urandom(), $urandom()}));
        end
      end
      setMem(memChoices[$urandom_range(0, 3)], AW'($urandom()), BW'({$urandom(), $urandom()}));
      reset = ($urandom_range(0, 99) != 0);
      runCycle();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
